// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the out-of-order back end: ROB tags,
// renamed operands, dispatched instructions and CDB bundles.
`default_nettype none

package uarch_pkg;

   localparam int XLEN       = 32;
   localparam int PIPE_WIDTH = 2;
   localparam int ROB_TAG_W  = 5;

   localparam int ALU_RS_DEPTH = 8;
   localparam int MDU_RS_DEPTH = 4;
   localparam int LSQ_RS_DEPTH = 8;

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_MUL   = 4'd7,
      OP_DIV   = 4'd8,
      OP_LOAD  = 4'd9,
      OP_STORE = 4'd10
   } fu_op_e;

   // is_renamed=1: data is not yet valid, the operand waits on tag.
   typedef struct packed {
      logic [XLEN-1:0] data;
      rob_tag_t        tag;
      logic            is_renamed;
   } operand_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      fu_op_e          op;
      rob_tag_t        rob_tag;
      operand_t        src_0;
      operand_t        src_1;
   } instruction_t;

   typedef struct packed {
      logic            valid;
      rob_tag_t        tag;
      logic [XLEN-1:0] data;
   } cdb_t;

   function automatic logic operands_ready(instruction_t inst);
      return !inst.src_0.is_renamed && !inst.src_1.is_renamed;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rs_find_first.sv
// Find-first-N priority encoder: reports the indices of the N lowest set
// bits of req_i, lowest first.
`default_nettype none

module rs_find_first #(
   parameter int WIDTH = 8,
   parameter int N     = 2,
   parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]          req_i,
   output logic [N-1:0]              valid_o,
   output logic [N-1:0][IDX_W-1:0]   idx_o
);

   always_comb begin
      logic [WIDTH-1:0] rem;
      logic             found;
      rem     = req_i;
      valid_o = '0;
      idx_o   = '0;
      for (int k = 0; k < N; k++) begin
         found = 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            if (rem[i] && !found) begin
               found     = 1'b1;
               idx_o[k]  = i[IDX_W-1:0];
               rem[i]    = 1'b0;
            end
         end
         valid_o[k] = found;
      end
   end

endmodule

`default_nettype wire

// File: rtl/reservation_station.sv
// Out-of-order reservation station: dispatch writes, CDB wakeup, and
// lowest-index select of one fully ready instruction per cycle.
`default_nettype none

module reservation_station
   import uarch_pkg::*;
#(
   parameter int RS_DEPTH  = ALU_RS_DEPTH,
   parameter int CDB_PORTS = PIPE_WIDTH
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              flush_i,
   output logic [PIPE_WIDTH-1:0]             rs_rdy_o,
   input  logic [PIPE_WIDTH-1:0]             rs_we_i,
   input  instruction_t [PIPE_WIDTH-1:0]     rs_entries_i,
   input  logic [CDB_PORTS-1:0]              cdb_valid_i,
   input  rob_tag_t [CDB_PORTS-1:0]          cdb_tag_i,
   input  logic [CDB_PORTS-1:0][XLEN-1:0]    cdb_data_i,
   output logic                              issue_valid_o,
   input  logic                              issue_rdy_i,
   output instruction_t                      issue_inst_o
);

   localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   logic [RS_DEPTH-1:0]                valid_q, valid_d;
   instruction_t [RS_DEPTH-1:0]        entry_q, entry_d;
   logic                               hold_q, hold_d;
   logic [IDX_W-1:0]                   hold_idx_q, hold_idx_d;

   logic [PIPE_WIDTH-1:0]              alloc_valid;
   logic [PIPE_WIDTH-1:0][IDX_W-1:0]   alloc_idx;
   logic [RS_DEPTH-1:0]                ready_vec;
   logic [0:0]                         sel_ff_valid;
   logic [0:0][IDX_W-1:0]              sel_ff_idx;
   logic [IDX_W-1:0]                   sel_idx;
   logic                               any_ready;

   // Lowest CDB port wins on a (non-legal) duplicate tag match.
   function automatic operand_t wake(operand_t op,
                                     logic [CDB_PORTS-1:0] cv,
                                     rob_tag_t [CDB_PORTS-1:0] ct,
                                     logic [CDB_PORTS-1:0][XLEN-1:0] cd);
      operand_t r;
      r = op;
      if (op.is_renamed) begin
         for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cv[p] && (ct[p] == op.tag)) begin
               r.data       = cd[p];
               r.is_renamed = 1'b0;
            end
         end
      end
      return r;
   endfunction

   rs_find_first #(
      .WIDTH (RS_DEPTH),
      .N     (PIPE_WIDTH),
      .IDX_W (IDX_W)
   ) u_alloc (
      .req_i   (~valid_q),
      .valid_o (alloc_valid),
      .idx_o   (alloc_idx)
   );

   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         ready_vec[i] = valid_q[i] && operands_ready(entry_q[i]);
      end
   end

   rs_find_first #(
      .WIDTH (RS_DEPTH),
      .N     (1),
      .IDX_W (IDX_W)
   ) u_select (
      .req_i   (ready_vec),
      .valid_o (sel_ff_valid),
      .idx_o   (sel_ff_idx)
   );

   // A stalled issue keeps its slot so issue_inst cannot jump to a lower
   // entry that wakes up while the execution unit is busy.
   assign sel_idx       = hold_q ? hold_idx_q : sel_ff_idx[0];
   assign any_ready     = hold_q | sel_ff_valid[0];
   assign issue_valid_o = any_ready & ~flush_i;
   assign issue_inst_o  = any_ready ? entry_q[sel_idx] : '0;

   // Bit k set means at least k+1 free slots, from registered state only.
   assign rs_rdy_o = alloc_valid;

   assign hold_d     = issue_valid_o & ~issue_rdy_i;
   assign hold_idx_d = sel_idx;

   always_comb begin
      int               n_wr;
      logic [IDX_W-1:0] wr_slot;
      valid_d = valid_q;
      entry_d = entry_q;
      n_wr    = 0;
      wr_slot = '0;

      for (int i = 0; i < RS_DEPTH; i++) begin
         if (valid_q[i]) begin
            entry_d[i].src_0 = wake(entry_q[i].src_0, cdb_valid_i, cdb_tag_i, cdb_data_i);
            entry_d[i].src_1 = wake(entry_q[i].src_1, cdb_valid_i, cdb_tag_i, cdb_data_i);
         end
      end

      if (issue_valid_o && issue_rdy_i) begin
         valid_d[sel_idx] = 1'b0;
      end

      for (int w = 0; w < PIPE_WIDTH; w++) begin
         if (rs_we_i[w] && rs_rdy_o[w]) begin
            for (int k = 0; k < PIPE_WIDTH; k++) begin
               if (n_wr == k) wr_slot = alloc_idx[k];
            end
            entry_d[wr_slot]       = rs_entries_i[w];
            entry_d[wr_slot].src_0 = wake(rs_entries_i[w].src_0, cdb_valid_i, cdb_tag_i, cdb_data_i);
            entry_d[wr_slot].src_1 = wake(rs_entries_i[w].src_1, cdb_valid_i, cdb_tag_i, cdb_data_i);
            valid_d[wr_slot]       = 1'b1;
            n_wr++;
         end
      end

      if (flush_i) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= '0;
         entry_q    <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
      end else begin
         valid_q    <= valid_d;
         entry_q    <= entry_d;
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
      end
   end

   a_no_write_without_space: assert property (
      @(posedge clk_i) disable iff (!rst_ni) ((rs_we_i & ~rs_rdy_o) == '0)
   );

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
// Directed, table-driven bench for reservation_station with hand-written
// sequences for full/hold/flush/async-reset corner cases.
`default_nettype none

module tb_reservation_station;
   import uarch_pkg::*;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic                          flush;
   logic [1:0]                    rs_rdy;
   logic [1:0]                    rs_we;
   instruction_t [1:0]            rs_entries;
   logic [1:0]                    cdb_valid;
   rob_tag_t [1:0]                cdb_tag;
   logic [1:0][31:0]              cdb_data;
   logic                          issue_valid;
   logic                          issue_rdy;
   instruction_t                  issue_inst;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reservation_station #(
      .RS_DEPTH  (8),
      .CDB_PORTS (2)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .rs_rdy_o      (rs_rdy),
      .rs_we_i       (rs_we),
      .rs_entries_i  (rs_entries),
      .cdb_valid_i   (cdb_valid),
      .cdb_tag_i     (cdb_tag),
      .cdb_data_i    (cdb_data),
      .issue_valid_o (issue_valid),
      .issue_rdy_i   (issue_rdy),
      .issue_inst_o  (issue_inst)
   );

   typedef struct {
      string       name;
      logic [1:0]  we;
      logic [31:0] pc0;
      logic        w0;
      logic [4:0]  t0;
      logic [31:0] pc1;
      logic        w1;
      logic [4:0]  t1;
      logic        cv;
      logic [4:0]  ctag;
      logic [31:0] cdata;
      logic        rdy;
      logic [1:0]  e_rdy;
      logic        e_iv;
      logic [31:0] e_pc;
      logic [31:0] e_d0;
   } vec_t;

   // Ready sources carry pc+0x100 so the issued data is traceable.
   function automatic instruction_t mk_inst(logic [31:0] pc, logic wt, logic [4:0] tag);
      instruction_t r;
      r                  = '0;
      r.pc               = pc;
      r.op               = OP_ADD;
      r.rob_tag          = tag;
      r.src_0.is_renamed = wt;
      r.src_0.tag        = tag;
      r.src_0.data       = wt ? 32'h0 : pc + 32'h100;
      r.src_1.data       = 32'h7;
      return r;
   endfunction

   function automatic vec_t mkv(string nm, logic [1:0] we,
                                logic [31:0] pc0, logic w0, logic [4:0] t0,
                                logic [31:0] pc1, logic w1, logic [4:0] t1,
                                logic cv, logic [4:0] ctag, logic [31:0] cdata,
                                logic rdy, logic [1:0] e_rdy, logic e_iv,
                                logic [31:0] e_pc, logic [31:0] e_d0);
      vec_t v;
      v.name = nm; v.we = we;
      v.pc0 = pc0; v.w0 = w0; v.t0 = t0;
      v.pc1 = pc1; v.w1 = w1; v.t1 = t1;
      v.cv = cv; v.ctag = ctag; v.cdata = cdata; v.rdy = rdy;
      v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_pc = e_pc; v.e_d0 = e_d0;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      flush     = 1'b0;
      rs_we     = 2'b00;
      rs_entries = '0;
      cdb_valid = 2'b00;
      cdb_tag   = '0;
      cdb_data  = '0;
      issue_rdy = 1'b0;
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = mkv("reset_idle",   2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
      vecs[1]  = mkv("wr_ready",     2'b01, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
      vecs[2]  = mkv("issue_first",  2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 1, 32'h10, 32'h110);
      vecs[3]  = mkv("freed",        2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0);
      vecs[4]  = mkv("wr_wait5",     2'b01, 32'h20, 1, 5, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0);
      vecs[5]  = mkv("wait5",        2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0);
      vecs[6]  = mkv("cdb5_nobyp",   2'b00, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEAD, 1, 2'b11, 0, 0, 0);
      vecs[7]  = mkv("woken5",       2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 1, 32'h20, 32'hDEAD);
      vecs[8]  = mkv("empty2",       2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0);
      vecs[9]  = mkv("dual_wr_cdb3", 2'b11, 32'h30, 0, 0, 32'h34, 1, 3, 1, 3, 32'hBEEF, 0, 2'b11, 0, 0, 0);
      vecs[10] = mkv("dual_first",   2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 1, 32'h30, 32'h130);
      vecs[11] = mkv("dual_second",  2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 1, 32'h34, 32'hBEEF);
      vecs[12] = mkv("empty3",       2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0);

      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 13; v++) begin
         if (v != 0) @(negedge clk);
         idle();
         rs_we         = vecs[v].we;
         rs_entries[0] = mk_inst(vecs[v].pc0, vecs[v].w0, vecs[v].t0);
         rs_entries[1] = mk_inst(vecs[v].pc1, vecs[v].w1, vecs[v].t1);
         cdb_valid[0]  = vecs[v].cv;
         cdb_tag[0]    = vecs[v].ctag;
         cdb_data[0]   = vecs[v].cdata;
         issue_rdy     = vecs[v].rdy;
         #1;
         chk({vecs[v].name, ".rs_rdy"}, 32'(rs_rdy), 32'(vecs[v].e_rdy));
         chk({vecs[v].name, ".issue_valid"}, 32'(issue_valid), 32'(vecs[v].e_iv));
         if (vecs[v].e_iv) begin
            chk({vecs[v].name, ".pc"}, issue_inst.pc, vecs[v].e_pc);
            chk({vecs[v].name, ".src0"}, issue_inst.src_0.data, vecs[v].e_d0);
         end
      end

      // Fill all 8 slots with waiting entries: slot s has pc 0x100+4s, tag 10+s.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         idle();
         rs_we         = 2'b11;
         rs_entries[0] = mk_inst(32'h100 + 32'(8 * k), 1'b1, 5'(10 + 2 * k));
         rs_entries[1] = mk_inst(32'h104 + 32'(8 * k), 1'b1, 5'(11 + 2 * k));
         issue_rdy     = 1'b1;
         #1;
         chk("fill.rs_rdy", 32'(rs_rdy), 32'h3);
         chk("fill.issue_valid", 32'(issue_valid), 32'h0);
      end
      @(negedge clk); idle(); issue_rdy = 1'b1; #1;
      chk("full.rs_rdy", 32'(rs_rdy), 32'h0);
      chk("full.issue_valid", 32'(issue_valid), 32'h0);
      @(negedge clk); idle(); issue_rdy = 1'b1;
      cdb_valid[1] = 1'b1; cdb_tag[1] = 5'd13; cdb_data[1] = 32'h1313; #1;
      chk("cdb13.issue_valid", 32'(issue_valid), 32'h0);
      @(negedge clk); idle(); issue_rdy = 1'b1; #1;
      chk("full_issue.issue_valid", 32'(issue_valid), 32'h1);
      chk("full_issue.pc", issue_inst.pc, 32'h10C);
      chk("full_issue.src0", issue_inst.src_0.data, 32'h1313);
      chk("full_issue.rs_rdy", 32'(rs_rdy), 32'h0);
      @(negedge clk); idle(); #1;
      chk("one_free.rs_rdy", 32'(rs_rdy), 32'h1);
      chk("one_free.issue_valid", 32'(issue_valid), 32'h0);

      // Stall slot 5 while lower slot 1 wakes up behind it.
      @(negedge clk); idle();
      cdb_valid[0] = 1'b1; cdb_tag[0] = 5'd15; cdb_data[0] = 32'h1515; #1;
      chk("wake15.issue_valid", 32'(issue_valid), 32'h0);
      @(negedge clk); idle();
      cdb_valid[0] = 1'b1; cdb_tag[0] = 5'd11; cdb_data[0] = 32'h1111; #1;
      chk("hold0.issue_valid", 32'(issue_valid), 32'h1);
      chk("hold0.pc", issue_inst.pc, 32'h114);
      chk("hold0.src0", issue_inst.src_0.data, 32'h1515);
      for (int k = 1; k < 3; k++) begin
         @(negedge clk); idle(); #1;
         chk("hold.issue_valid", 32'(issue_valid), 32'h1);
         chk("hold.pc", issue_inst.pc, 32'h114);
      end
      @(negedge clk); idle();
      flush = 1'b1; rs_we = 2'b01; rs_entries[0] = mk_inst(32'h200, 1'b0, 5'd0); #1;
      chk("flush.issue_valid", 32'(issue_valid), 32'h0);
      @(negedge clk); idle(); #1;
      chk("post_flush.rs_rdy", 32'(rs_rdy), 32'h3);
      chk("post_flush.issue_valid", 32'(issue_valid), 32'h0);
      @(negedge clk); idle(); issue_rdy = 1'b1; #1;
      chk("flush_wr_dropped.issue_valid", 32'(issue_valid), 32'h0);

      // Burst of ready entries, then asynchronous reset mid-cycle.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         idle();
         rs_we         = 2'b11;
         rs_entries[0] = mk_inst(32'h300 + 32'(8 * k), 1'b0, 5'd0);
         rs_entries[1] = mk_inst(32'h304 + 32'(8 * k), 1'b0, 5'd0);
      end
      @(negedge clk); idle(); #1;
      chk("burst.rs_rdy", 32'(rs_rdy), 32'h0);
      chk("burst.issue_valid", 32'(issue_valid), 32'h1);
      chk("burst.pc", issue_inst.pc, 32'h300);
      rst_n = 1'b0;
      #1;
      chk("async_rst.rs_rdy", 32'(rs_rdy), 32'h3);
      chk("async_rst.issue_valid", 32'(issue_valid), 32'h0);
      chk("async_rst.pc", issue_inst.pc, 32'h0);
      chk("async_rst.src0", issue_inst.src_0.data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      issue_rdy = 1'b1;
      #1;
      chk("after_rst.issue_valid", 32'(issue_valid), 32'h0);
      chk("after_rst.rs_rdy", 32'(rs_rdy), 32'h3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
